// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier: FSM states, flag bit
// positions and field-classification helpers usable for any exponent/fraction
// width up to a 64-bit encoding.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Callers pass the whole encoding zero-extended to 64 bits.
  function automatic logic [63:0] fp_exp_field(input int exp_w, input int man_w,
                                               input logic [63:0] x);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac_field(input int man_w, input logic [63:0] x);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic fp_is_nan(input int exp_w, input int man_w, input logic [63:0] x);
    return (fp_exp_field(exp_w, man_w, x) == ((64'd1 << exp_w) - 64'd1)) &&
           (fp_frac_field(man_w, x) != 64'd0);
  endfunction

  function automatic logic fp_is_inf(input int exp_w, input int man_w, input logic [63:0] x);
    return (fp_exp_field(exp_w, man_w, x) == ((64'd1 << exp_w) - 64'd1)) &&
           (fp_frac_field(man_w, x) == 64'd0);
  endfunction

  // Denormals are flushed: any operand with a zero exponent field counts as zero.
  function automatic logic fp_is_zero(input int exp_w, input int man_w, input logic [63:0] x);
    return fp_exp_field(exp_w, man_w, x) == 64'd0;
  endfunction

  // Positive quiet NaN: exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mant_shiftadd.sv
// Iterative radix-2 shift-add unsigned multiplier. start loads the operands;
// one partial product is accumulated per cycle for N cycles. done is high
// during the cycle whose edge performs the final step, so product is complete
// in the cycle after done.
module fp_mant_shiftadd #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic [N-1:0]   mcand_reg;
  logic [2*N-1:0] prod_reg;
  logic [N:0]     sum_next;
  logic [2*N-1:0] prod_next;

  // One step: add the multiplicand to the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    sum_next  = {1'b0, prod_reg[2*N-1:N]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    prod_next = {sum_next, prod_reg[N-1:1]};
  end

  // Operand load on start, then count down from N-1 to 0 applying one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      prod_reg  <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      cnt_reg   <= CW'(N - 1);
      mcand_reg <= mcand;
      prod_reg  <= {{N{1'b0}}, mplier};
    end else if (busy_reg) begin
      prod_reg <= prod_next;
      if (cnt_reg == '0) busy_reg <= 1'b0;
      else               cnt_reg  <= cnt_reg - 1'b1;
    end
  end

  assign done    = busy_reg && (cnt_reg == '0);
  assign product = prod_reg;

endmodule

// File: rtl/fp_mul_iterative_pipe.sv
// Sequential floating-point multiplier with valid/ready on both sides.
// Fixed latency for every operand class: specials are resolved at unpack time
// but still travel through the multiply/normalise/round states.
module fp_mul_iterative_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int RND_RNE = 1,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int M    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = EW'(0);

  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg;
  logic                  sign_reg;
  logic                  spec_reg;
  logic [W-1:0]          spec_res_reg;
  logic [3:0]            spec_flg_reg;
  logic signed [EW-1:0]  exp_reg;
  logic [2*M-1:0]        norm_reg;
  logic [W-1:0]          result_reg;
  logic [3:0]            flags_reg;

  logic                  mul_start, mul_done;
  logic [2*M-1:0]        mul_product;

  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab;
  logic                  spec_hit;
  logic [W-1:0]          spec_res;
  logic [3:0]            spec_flg;

  logic [M-1:0]          mant;
  logic                  guard_bit, sticky_bit, round_up;
  logic [M:0]            mant_rnd;
  logic signed [EW-1:0]  exp_rnd;
  logic [MAN_W-1:0]      frac_rnd;
  logic [W-1:0]          res_rnd;
  logic [3:0]            flg_rnd;

  assign a_nan   = fp_is_nan(EXP_W, MAN_W, 64'(a_reg));
  assign b_nan   = fp_is_nan(EXP_W, MAN_W, 64'(b_reg));
  assign a_inf   = fp_is_inf(EXP_W, MAN_W, 64'(a_reg));
  assign b_inf   = fp_is_inf(EXP_W, MAN_W, 64'(b_reg));
  assign a_zero  = fp_is_zero(EXP_W, MAN_W, 64'(a_reg));
  assign b_zero  = fp_is_zero(EXP_W, MAN_W, 64'(b_reg));
  assign sign_ab = a_reg[W-1] ^ b_reg[W-1];

  // Special-operand result in priority order: NaN, inf*0, inf, zero.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan) begin
      spec_res = W'(fp_qnan(EXP_W, MAN_W));
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_res          = W'(fp_qnan(EXP_W, MAN_W));
      spec_flg[FLG_INV] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {sign_ab, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign mul_start = (state_reg == UNPACK);

  fp_mant_shiftadd #(.N(M)) u_mant (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   ({1'b1, a_reg[MAN_W-1:0]}),
    .mplier  ({1'b1, b_reg[MAN_W-1:0]}),
    .done    (mul_done),
    .product (mul_product)
  );

  // Round the normalised product: guard is the first dropped bit, everything below folds into sticky.
  always_comb begin
    mant       = norm_reg[2*M-1:M];
    guard_bit  = norm_reg[M-1];
    sticky_bit = |norm_reg[M-2:0];
    round_up   = (RND_RNE != 0) && guard_bit && (sticky_bit || mant[0]);
    mant_rnd   = {1'b0, mant} + {{M{1'b0}}, round_up};
    exp_rnd    = mant_rnd[M] ? exp_reg + ONE_S : exp_reg;
    frac_rnd   = mant_rnd[M] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    res_rnd    = {sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
    flg_rnd    = '0;
    flg_rnd[FLG_INX] = guard_bit | sticky_bit;
    if (spec_reg) begin
      res_rnd = spec_res_reg;
      flg_rnd = spec_flg_reg;
    end else if (exp_rnd >= EMAX_S) begin
      res_rnd          = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_rnd[FLG_OVF] = 1'b1;
      flg_rnd[FLG_INX] = 1'b1;
    end else if (exp_rnd <= ZERO_S) begin
      res_rnd          = {sign_reg, {(W-1){1'b0}}};
      flg_rnd[FLG_UNF] = 1'b1;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == IDLE) && !rst;
    out_valid  = (state_reg == DONE);
    case (state_reg)
      IDLE:    if (in_valid && in_ready) state_next = UNPACK;
      UNPACK:  state_next = MULT;
      MULT:    if (mul_done) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath: operand capture, classification, exponent sum, normalisation and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sign_reg     <= 1'b0;
      spec_reg     <= 1'b0;
      spec_res_reg <= '0;
      spec_flg_reg <= '0;
      exp_reg      <= '0;
      norm_reg     <= '0;
      result_reg   <= '0;
      flags_reg    <= '0;
    end else begin
      if (in_valid && in_ready) begin
        a_reg <= a;
        b_reg <= b;
      end
      if (state_reg == UNPACK) begin
        sign_reg     <= sign_ab;
        spec_reg     <= spec_hit;
        spec_res_reg <= spec_res;
        spec_flg_reg <= spec_flg;
        exp_reg      <= signed'({2'b00, a_reg[W-2:MAN_W]}) +
                        signed'({2'b00, b_reg[W-2:MAN_W]}) - BIAS_S;
      end
      // Place the leading one at the top bit; a product >= 2.0 bumps the exponent.
      if (state_reg == NORM) begin
        if (mul_product[2*M-1]) begin
          norm_reg <= mul_product;
          exp_reg  <= exp_reg + ONE_S;
        end else begin
          norm_reg <= {mul_product[2*M-2:0], 1'b0};
        end
      end
      if (state_reg == ROUND) begin
        result_reg <= res_rnd;
        flags_reg  <= flg_rnd;
      end
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;

endmodule
